// File: rtl/noc_sequencer_if.sv
// Control bundle between the NoC simulator top level and the network-phase sequencer.
interface noc_sequencer_if #(
   parameter int ROUTERS    = 16,
   parameter int RB         = 4,
   parameter int OP_W       = 4,
   parameter int CYCLE_W    = 32,
   parameter int FILL_DEPTH = 64
);
   localparam int FW = (FILL_DEPTH > 1) ? $clog2(FILL_DEPTH) : 1;

   logic                    i_start;
   logic                    i_stall;
   logic [CYCLE_W-1:0]      i_max_cycle;
   logic [ROUTERS-1:0]      i_fill_pending;
   logic [ROUTERS-1:0]      i_rt_valid;
   logic                    i_net_idle;
   logic                    o_rt_rd_en;
   logic [RB-1:0]           o_rt_rd_dst;
   logic [RB-1:0]           o_rt_dst;
   logic [FW-1:0]           o_fill_idx;
   logic [ROUTERS*OP_W-1:0] o_router_op;
   logic [ROUTERS*OP_W-1:0] o_traffic_op;
   logic [CYCLE_W-1:0]      o_in_cycle;
   logic                    o_busy;
   logic                    o_done;
   logic                    o_timeout;
   logic                    o_fill_overflow;

   modport slave (
      input  i_start, i_stall, i_max_cycle, i_fill_pending, i_rt_valid, i_net_idle,
      output o_rt_rd_en, o_rt_rd_dst, o_rt_dst, o_fill_idx, o_router_op, o_traffic_op,
             o_in_cycle, o_busy, o_done, o_timeout, o_fill_overflow
   );

   modport master (
      output i_start, i_stall, i_max_cycle, i_fill_pending, i_rt_valid, i_net_idle,
      input  o_rt_rd_en, o_rt_rd_dst, o_rt_dst, o_fill_idx, o_router_op, o_traffic_op,
             o_in_cycle, o_busy, o_done, o_timeout, o_fill_overflow
   );
endinterface

// File: rtl/noc_sequencer.sv
// Network-phase sequencer: traffic init/fill, router init, routing-table load, then the
// repeating LoadStaging/Phase0/Phase1 cycle until max_cycle or an idle network ends the run.
module noc_sequencer #(
   parameter int ROUTERS    = 16,
   parameter int RB         = 4,
   parameter int OP_W       = 4,
   parameter int CYCLE_W    = 32,
   parameter int FILL_DEPTH = 64
) (
   input logic            i_clk,
   input logic            i_rst_n,
   noc_sequencer_if.slave io_seq
);
   localparam int FW    = (FILL_DEPTH > 1) ? $clog2(FILL_DEPTH) : 1;
   localparam int OPS_W = ROUTERS * OP_W;

   localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_INIT   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LOADRT = OP_W'(2);
   localparam logic [OP_W-1:0] OP_STAGE  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_PH0    = OP_W'(4);
   localparam logic [OP_W-1:0] OP_PH1    = OP_W'(5);
   localparam logic [OP_W-1:0] OP_FILL   = OP_W'(7);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_TRAFFIC, S_FILL, S_INIT, S_LOAD_RT, S_STAGE, S_PH0, S_PH1, S_DONE
   } state_t;

   state_t             r_state, w_nextState;
   logic [OPS_W-1:0]   r_routerOp, w_routerOp;
   logic [OPS_W-1:0]   r_trafficOp, w_trafficOp;
   logic               r_rtRdEn, w_rtRdEn;
   logic [RB-1:0]      r_rtRdDst, w_rtRdDst;
   logic [RB-1:0]      r_rtDst, w_rtDst;
   logic [FW-1:0]      r_fillIdx, w_fillIdx;
   logic [CYCLE_W-1:0] r_inCycle, w_inCycle;
   logic               r_busy, w_busy;
   logic               r_done, w_done;
   logic               r_timeout, w_timeout;
   logic               r_fillOverflow, w_fillOverflow;
   logic               r_armed;

   logic [CYCLE_W-1:0] w_cycleInc;
   logic [RB-1:0]      w_kNext;
   logic               w_fillActive;
   logic               w_lastK;

   function automatic logic [OPS_W-1:0] maskedOp(input logic [ROUTERS-1:0] sel,
                                                 input logic [OP_W-1:0]    op);
      logic [OPS_W-1:0] v;
      v = '0;
      for (int i = 0; i < ROUTERS; i++) begin
         if (sel[i]) v[i*OP_W +: OP_W] = op;
      end
      return v;
   endfunction

   assign w_cycleInc   = r_inCycle + CYCLE_W'(1);
   assign w_kNext      = r_rtDst + RB'(1);
   assign w_fillActive = |r_trafficOp;
   assign w_lastK      = (r_rtDst == RB'(ROUTERS - 1));

   // Every output is registered together with the state, so the ops visible in a cycle are
   // decided at the edge that enters it; FILL and STAGE look back at their own ops to decide exit.
   always_comb begin
      w_nextState    = r_state;
      w_routerOp     = '0;
      w_trafficOp    = '0;
      w_rtRdEn       = 1'b0;
      w_rtRdDst      = '0;
      w_rtDst        = r_rtDst;
      w_fillIdx      = r_fillIdx;
      w_inCycle      = r_inCycle;
      w_done         = r_done;
      w_timeout      = r_timeout;
      w_fillOverflow = r_fillOverflow;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (io_seq.i_start && r_armed) begin
               w_nextState    = S_INIT_TRAFFIC;
               w_trafficOp    = maskedOp('1, OP_INIT);
               w_inCycle      = '0;
               w_fillIdx      = '0;
               w_timeout      = 1'b0;
               w_fillOverflow = 1'b0;
               w_done         = 1'b0;
            end
         end
         S_INIT_TRAFFIC: begin
            w_nextState = S_FILL;
            w_trafficOp = maskedOp(io_seq.i_fill_pending, OP_FILL);
         end
         S_FILL: begin
            if (!w_fillActive || (r_fillIdx == FW'(FILL_DEPTH - 1))) begin
               if (w_fillActive) w_fillOverflow = 1'b1;
               w_nextState = S_INIT;
               w_routerOp  = maskedOp('1, OP_INIT);
               w_rtRdEn    = 1'b1;
               w_rtRdDst   = '0;
            end else begin
               w_fillIdx   = r_fillIdx + FW'(1);
               w_trafficOp = maskedOp(io_seq.i_fill_pending, OP_FILL);
            end
         end
         S_INIT: begin
            w_nextState = S_LOAD_RT;
            w_routerOp  = maskedOp(io_seq.i_rt_valid, OP_LOADRT);
            w_rtDst     = '0;
            w_rtRdEn    = 1'b1;
            w_rtRdDst   = RB'(1);
         end
         S_LOAD_RT: begin
            if (!w_lastK) begin
               w_routerOp = maskedOp(io_seq.i_rt_valid, OP_LOADRT);
               w_rtDst    = w_kNext;
               if (w_kNext != RB'(ROUTERS - 1)) begin
                  w_rtRdEn  = 1'b1;
                  w_rtRdDst = w_kNext + RB'(1);
               end
            end else begin
               w_nextState = S_STAGE;
               w_routerOp  = io_seq.i_stall ? '0 : maskedOp('1, OP_STAGE);
            end
         end
         S_STAGE: begin
            if (r_routerOp[OP_W-1:0] == OP_NOP) begin
               w_routerOp = io_seq.i_stall ? '0 : maskedOp('1, OP_STAGE);
            end else begin
               w_nextState = S_PH0;
               w_routerOp  = maskedOp('1, OP_PH0);
            end
         end
         S_PH0: begin
            w_nextState = S_PH1;
            w_routerOp  = maskedOp('1, OP_PH1);
         end
         S_PH1: begin
            w_inCycle = w_cycleInc;
            if ((io_seq.i_max_cycle != '0) && (w_cycleInc == io_seq.i_max_cycle)) begin
               w_nextState = S_DONE;
               w_timeout   = 1'b1;
               w_done      = 1'b1;
            end else if (io_seq.i_net_idle) begin
               w_nextState = S_DONE;
               w_done      = 1'b1;
            end else begin
               w_nextState = S_STAGE;
               w_routerOp  = io_seq.i_stall ? '0 : maskedOp('1, OP_STAGE);
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase

      w_busy = !((w_nextState == S_IDLE) || (w_nextState == S_DONE));
   end

   // State and output registers; reset abandons any run in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_routerOp     <= '0;
         r_trafficOp    <= '0;
         r_rtRdEn       <= 1'b0;
         r_rtRdDst      <= '0;
         r_rtDst        <= '0;
         r_fillIdx      <= '0;
         r_inCycle      <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_timeout      <= 1'b0;
         r_fillOverflow <= 1'b0;
      end else begin
         r_state        <= w_nextState;
         r_routerOp     <= w_routerOp;
         r_trafficOp    <= w_trafficOp;
         r_rtRdEn       <= w_rtRdEn;
         r_rtRdDst      <= w_rtRdDst;
         r_rtDst        <= w_rtDst;
         r_fillIdx      <= w_fillIdx;
         r_inCycle      <= w_inCycle;
         r_busy         <= w_busy;
         r_done         <= w_done;
         r_timeout      <= w_timeout;
         r_fillOverflow <= w_fillOverflow;
      end
   end

   // A start seen on the first edge after reset release is deliberately dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   assign io_seq.o_rt_rd_en      = r_rtRdEn;
   assign io_seq.o_rt_rd_dst     = r_rtRdDst;
   assign io_seq.o_rt_dst        = r_rtDst;
   assign io_seq.o_fill_idx      = r_fillIdx;
   assign io_seq.o_router_op     = r_routerOp;
   assign io_seq.o_traffic_op    = r_trafficOp;
   assign io_seq.o_in_cycle      = r_inCycle;
   assign io_seq.o_busy          = r_busy;
   assign io_seq.o_done          = r_done;
   assign io_seq.o_timeout       = r_timeout;
   assign io_seq.o_fill_overflow = r_fillOverflow;
endmodule

// File: tb/tb_noc_sequencer.sv
// Run-level bench for noc_sequencer: walks each network phase in order and predicts every
// cycle's ops from the phase rules, with directed runs followed by randomised ones.
module tb_noc_sequencer;
   localparam int ROUTERS    = 4;
   localparam int RB         = 2;
   localparam int OP_W       = 4;
   localparam int CYCLE_W    = 32;
   localparam int FILL_DEPTH = 4;
   localparam int OPS_W      = ROUTERS * OP_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   nChecks = 0;
   int   nFail   = 0;

   logic [ROUTERS-1:0] rtTable [ROUTERS];
   logic [ROUTERS-1:0] fillMasks [$];
   int                 stallLens [64];

   noc_sequencer_if #(
      .ROUTERS(ROUTERS), .RB(RB), .OP_W(OP_W), .CYCLE_W(CYCLE_W), .FILL_DEPTH(FILL_DEPTH)
   ) seqIf ();

   noc_sequencer #(
      .ROUTERS(ROUTERS), .RB(RB), .OP_W(OP_W), .CYCLE_W(CYCLE_W), .FILL_DEPTH(FILL_DEPTH)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_seq (seqIf.slave)
   );

   always #5 clk = ~clk;

   // Routing-table memory: answers the strobe visible this cycle, sampled at the next edge.
   assign seqIf.i_rt_valid = seqIf.o_rt_rd_en ? rtTable[seqIf.o_rt_rd_dst] : '0;

   function automatic logic [OPS_W-1:0] opsFor(input logic [ROUTERS-1:0] sel, input int op);
      logic [OPS_W-1:0] v;
      v = '0;
      for (int i = 0; i < ROUTERS; i++) begin
         if (sel[i]) v[i*OP_W +: OP_W] = OP_W'(op);
      end
      return v;
   endfunction

   function automatic logic rndBit();
      return 1'($urandom_range(1));
   endfunction

   function automatic logic [ROUTERS-1:0] rndVec();
      return ROUTERS'($urandom);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic startV, input logic stallV, input logic idleV,
                                input logic [ROUTERS-1:0] pendV);
      seqIf.i_start        = startV;
      seqIf.i_stall        = stallV;
      seqIf.i_net_idle     = idleV;
      seqIf.i_fill_pending = pendV;
      @(posedge clk);
      #1;
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, " ops/cycle"},
                  {seqIf.o_router_op, seqIf.o_traffic_op, seqIf.o_in_cycle}, 64'd0);
      checkOutput({tag, " flags"},
                  {seqIf.o_busy, seqIf.o_done, seqIf.o_timeout, seqIf.o_fill_overflow,
                   seqIf.o_rt_rd_en, seqIf.o_fill_idx, seqIf.o_rt_rd_dst, seqIf.o_rt_dst}, 64'd0);
   endtask

   // One full run from IDLE/DONE; abortAt>0 pulls reset during Phase0 of that network cycle.
   task automatic runNetwork(input string name, input int maxC, input int idleAt, input int abortAt);
      logic [ROUTERS-1:0] pend;
      logic expOverflow;
      logic expTimeout;
      logic idleEdge;
      bit   stopNow;
      int   c;

      seqIf.i_max_cycle = CYCLE_W'(maxC);
      applyStimulus(1'b1, rndBit(), rndBit(), rndVec());
      checkOutput({name, " trafficInit"}, seqIf.o_traffic_op, opsFor('1, 1));
      checkOutput({name, " initRouterNop"}, seqIf.o_router_op, 64'd0);
      checkOutput({name, " busyInit"}, seqIf.o_busy, 64'd1);
      checkOutput({name, " clearedOnStart"},
                  {seqIf.o_done, seqIf.o_timeout, seqIf.o_fill_overflow, seqIf.o_fill_idx,
                   seqIf.o_in_cycle}, 64'd0);

      expOverflow = 1'b0;
      for (int j = 0; j < FILL_DEPTH; j++) begin
         pend = (j < fillMasks.size()) ? fillMasks[j] : '0;
         applyStimulus(rndBit(), rndBit(), rndBit(), pend);
         checkOutput($sformatf("%s fillOp%0d", name, j), seqIf.o_traffic_op, opsFor(pend, 7));
         checkOutput($sformatf("%s fillRouterNop%0d", name, j), seqIf.o_router_op, 64'd0);
         if (pend != '0) checkOutput($sformatf("%s fillIdx%0d", name, j), seqIf.o_fill_idx, j);
         if (pend == '0) break;
         if (j == FILL_DEPTH - 1) expOverflow = 1'b1;
      end

      applyStimulus(rndBit(), rndBit(), rndBit(), rndVec());
      checkOutput({name, " routerInit"}, seqIf.o_router_op, opsFor('1, 1));
      checkOutput({name, " trafficNopInit"}, seqIf.o_traffic_op, 64'd0);
      checkOutput({name, " firstRead"}, {seqIf.o_rt_rd_en, seqIf.o_rt_rd_dst}, {1'b1, RB'(0)});
      checkOutput({name, " overflow"}, seqIf.o_fill_overflow, expOverflow);

      for (int k = 0; k < ROUTERS; k++) begin
         applyStimulus(rndBit(), rndBit(), rndBit(), rndVec());
         checkOutput($sformatf("%s loadRt%0d", name, k), seqIf.o_router_op, opsFor(rtTable[k], 2));
         checkOutput($sformatf("%s rtDst%0d", name, k), seqIf.o_rt_dst, k);
         checkOutput($sformatf("%s rdEn%0d", name, k), seqIf.o_rt_rd_en, (k < ROUTERS - 1));
         if (k < ROUTERS - 1)
            checkOutput($sformatf("%s rdDst%0d", name, k), seqIf.o_rt_rd_dst, k + 1);
      end

      c        = 1;
      idleEdge = rndBit();
      stopNow  = 1'b0;
      while (!stopNow && c < 60) begin
         for (int s = 0; s < stallLens[c]; s++) begin
            applyStimulus(rndBit(), 1'b1, (s == 0) ? idleEdge : rndBit(), rndVec());
            checkOutput($sformatf("%s stallNop c%0d s%0d", name, c, s), seqIf.o_router_op, 64'd0);
         end
         applyStimulus(rndBit(), 1'b0, (stallLens[c] == 0) ? idleEdge : rndBit(), rndVec());
         checkOutput($sformatf("%s loadStaging c%0d", name, c), seqIf.o_router_op, opsFor('1, 3));
         checkOutput($sformatf("%s inCycle c%0d", name, c), seqIf.o_in_cycle, c - 1);
         applyStimulus(rndBit(), rndBit(), rndBit(), rndVec());
         checkOutput($sformatf("%s phase0 c%0d", name, c), seqIf.o_router_op, opsFor('1, 4));

         if (c == abortAt) begin
            #1 rst_n = 1'b0;
            #1;
            checkCleared({name, " asyncReset"});
            applyStimulus(1'b0, rndBit(), rndBit(), rndVec());
            checkCleared({name, " heldInReset"});
            rst_n = 1'b1;
            applyStimulus(1'b1, rndBit(), rndBit(), rndVec());
            checkCleared({name, " startOnRelease"});
            applyStimulus(1'b0, rndBit(), rndBit(), rndVec());
            checkCleared({name, " idleAfterReset"});
            return;
         end

         applyStimulus(rndBit(), rndBit(), rndBit(), rndVec());
         checkOutput($sformatf("%s phase1 c%0d", name, c), seqIf.o_router_op, opsFor('1, 5));
         checkOutput($sformatf("%s busyPh1 c%0d", name, c),
                     {seqIf.o_busy, seqIf.o_traffic_op}, {1'b1, 16'h0});

         expTimeout = (maxC != 0) && (c == maxC);
         idleEdge   = (c == idleAt);
         if (expTimeout || idleEdge) begin
            applyStimulus(1'b0, rndBit(), idleEdge, rndVec());
            checkOutput({name, " doneOps"}, {seqIf.o_router_op, seqIf.o_traffic_op}, 64'd0);
            checkOutput({name, " doneFlags"},
                        {seqIf.o_done, seqIf.o_busy, seqIf.o_timeout, seqIf.o_fill_overflow},
                        {1'b1, 1'b0, expTimeout, expOverflow});
            checkOutput({name, " doneCycle"}, seqIf.o_in_cycle, c);
            repeat (2) applyStimulus(1'b0, rndBit(), rndBit(), rndVec());
            checkOutput({name, " doneHeld"}, {seqIf.o_done, seqIf.o_busy, seqIf.o_in_cycle},
                        {1'b1, 1'b0, CYCLE_W'(c)});
            stopNow = 1'b1;
         end else begin
            c++;
         end
      end
      if (!stopNow) checkOutput({name, " runBound"}, c, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int maxC;
      int idleAt;
      int nMask;

      seqIf.i_start        = 1'b0;
      seqIf.i_stall        = 1'b0;
      seqIf.i_net_idle     = 1'b0;
      seqIf.i_fill_pending = '0;
      seqIf.i_max_cycle    = '0;
      for (int d = 0; d < ROUTERS; d++) rtTable[d] = '1;
      for (int i = 0; i < 64; i++) stallLens[i] = 0;

      repeat (3) @(posedge clk);
      #1;
      checkCleared("reset");
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkCleared("idleAfterRelease");

      // Empty fill, all routes valid, three network cycles ending in timeout.
      fillMasks.delete();
      runNetwork("tp1", 3, 0, 0);

      // Two fill cycles on sources 0 and 1, checkerboard routing table.
      repeat (2) fillMasks.push_back(4'b0011);
      for (int d = 0; d < ROUTERS; d++) rtTable[d] = 4'b0101;
      runNetwork("tp2", 2, 0, 0);

      // Five-cycle stall on first STAGE entry, unlimited cycles, idle after first Phase1.
      fillMasks.delete();
      stallLens[1] = 5;
      runNetwork("tp4", 0, 1, 0);
      stallLens[1] = 0;

      // Source 3 never drains: fill stops at FILL_DEPTH and flags overflow.
      repeat (6) fillMasks.push_back(4'b1000);
      runNetwork("overflow", 1, 0, 0);

      // Timeout and idle on the same Phase1: timeout wins.
      fillMasks.delete();
      runNetwork("tieBreak", 2, 2, 0);

      // Reset during Phase0 of network cycle 2, then a start on the release edge.
      runNetwork("abort", 0, 5, 2);

      for (int r = 0; r < 25; r++) begin
         fillMasks.delete();
         nMask = $urandom_range(0, 5);
         for (int m = 0; m < nMask; m++) fillMasks.push_back(ROUTERS'($urandom_range(1, 15)));
         for (int d = 0; d < ROUTERS; d++) rtTable[d] = rndVec();
         for (int i = 1; i < 64; i++) stallLens[i] = $urandom_range(0, 2);
         maxC   = $urandom_range(0, 4);
         idleAt = (maxC == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
         runNetwork($sformatf("rnd%0d", r), maxC, idleAt, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule

// File: doc/noc_sequencer.md
Name: noc_sequencer

Overview:
- Synthesisable, parametrised network-phase sequencer for the NoC simulator top level. Replaces the hard-coded 4-router initial/always state machine.
- Drives per-router `router_op` and per-source `traffic_op` for the full run: traffic init, traffic fill, router init, routing-table load, then the repeating LoadStaging/Phase0/Phase1 cycle.
- New over the previous generation:
  - registered routing-table read interface;
  - stall;
  - max-cycle timeout;
  - idle-network early termination;
  - fill-overflow detection;
  - restartable run.

Parameters:
- ROUTERS, 16, number of routers/traffic sources (>=2).
- RB, 4, router index width, ceil(log2(ROUTERS)).
- OP_W, 4, op code width.
- CYCLE_W, 32, simulated-cycle counter width.
- FILL_DEPTH, 64, max packets per source; fill index width FW = ceil(log2(FILL_DEPTH)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request, sampled in IDLE or DONE only.
- stall  in  1  hold network before next LoadStaging.
- max_cycle  in  CYCLE_W  cycle limit; 0 = unlimited.
- fill_pending  in  ROUTERS  source i still has packets to fill.
- rt_valid  in  ROUTERS  routing-table entry [i][dst] valid; response to read issued previous cycle.
- net_idle  in  1  all routers empty and all traffic queues empty.
- rt_rd_en  out  1  routing-table read strobe.
- rt_rd_dst  out  RB  destination column being read.
- rt_dst  out  RB  destination accompanying LoadRt.
- fill_idx  out  FW  packet index accompanying Fill.
- router_op  out  ROUTERS*OP_W  op for router i in slice i.
- traffic_op  out  ROUTERS*OP_W  op for traffic source i.
- in_cycle  out  CYCLE_W  simulated cycle count.
- busy  out  1  run in progress.
- done  out  1  run finished (sticky until start/reset).
- timeout  out  1  run ended by max_cycle.
- fill_overflow  out  1  sticky; fill stopped at FILL_DEPTH with sources still pending.

Behaviour:
- Op encoding (fixed): NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5, InitTraffic=6 (internal state only), Fill=7.
- All outputs registered. The ops shown belong to the state the FSM currently occupies.
- Reset (asynchronous): state IDLE; all ops NOP; all counters, flags, rt_rd_en, busy and done are 0. This also applies mid-run, with no partial completion.
- States: IDLE, INIT_TRAFFIC, FILL, INIT, LOAD_RT, STAGE, PH0, PH1, DONE.
- IDLE/DONE: start=1 -> INIT_TRAFFIC. On that transition, clear in_cycle, fill_idx, timeout, fill_overflow and done.
- busy=1 in every state except IDLE/DONE. start is ignored while busy.
- INIT_TRAFFIC (1 cycle): traffic_op all = Init (encoding 1). Go to FILL.
- FILL:
  - traffic_op[i]=Fill where fill_pending[i], else NOP; fill_idx then increments.
  - fill_pending==0: all NOP; go to INIT.
  - fill_idx==FILL_DEPTH-1 with pending nonzero: issue this last Fill, set fill_overflow, go to INIT.
- INIT (1 cycle): router_op all Init; rt_rd_en=1, rt_rd_dst=0. Go to LOAD_RT with k=0.
- LOAD_RT (exactly ROUTERS cycles):
  - Cycle k: router_op[i]=LoadRt if rt_valid[i], else NOP; rt_dst=k.
  - While k<ROUTERS-1: rt_rd_en=1, rt_rd_dst=k+1. In the last cycle rt_rd_en=0.
  - After k=ROUTERS-1, go to STAGE.
- STAGE:
  - stall=1: all router_op NOP; remain in STAGE.
  - else: all router_op LoadStaging; go to PH0.
- PH0: all router_op Phase0; go to PH1.
- PH1: all router_op Phase1. in_cycle increments at end of cycle (wraps at 2^CYCLE_W). Next state, in priority order:
  - max_cycle!=0 and in_cycle+1==max_cycle -> DONE, timeout=1.
  - else net_idle=1 -> DONE, timeout=0.
  - else -> STAGE.
- DONE: all ops NOP; done=1; in_cycle held.
- traffic_op is NOP outside INIT_TRAFFIC/FILL. router_op is NOP in IDLE/INIT_TRAFFIC/FILL/DONE.
- Simultaneous events:
  - timeout beats net_idle.
  - stall has no effect outside STAGE.
  - start in the same cycle as reset deassertion is ignored.

Test Plan:
- ROUTERS=4, rst_n low then high, start pulse, fill_pending=0, rt_valid=4'b1111, net_idle=0, max_cycle=3 -> INIT_TRAFFIC, FILL (1 cycle, all NOP), INIT, then LOAD_RT with rt_dst 0,1,2,3. Then 3×(LoadStaging, Phase0, Phase1); done=1, timeout=1, in_cycle=3.
- fill_pending=4'b0011 for 2 cycles then 0 -> sources 0,1 get Fill with fill_idx 0 then 1; sources 2,3 NOP; fill_overflow=0.
- rt_valid=4'b0101 throughout LOAD_RT -> routers 0,2 LoadRt and routers 1,3 NOP each cycle; rt_rd_dst sequence 0,1,2,3 one cycle ahead of rt_dst.
- stall high 5 cycles on STAGE entry, max_cycle=0, net_idle=1 in first PH1 -> 5 NOP cycles, then LoadStaging, Phase0, Phase1; DONE with timeout=0, in_cycle=1.
- FILL_DEPTH=4, fill_pending=4'b1000 held -> 4 Fill cycles (fill_idx 0..3), then fill_overflow=1 and INIT.
- rst_n low during PH0 of cycle 2 -> all outputs 0/NOP immediately. After release with no start, stays IDLE, busy=0, done=0.
